// File: rtl/regfile_wb_scheduler_if.sv
// Bundles the issue, write-back request and register-file write signals of the
// write-back scheduler. The scheduler uses the slave view, its neighbours the master view.
interface regfile_wb_scheduler_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
);
  // Issue stage hazard query
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   issue_src1;
  logic [AW-1:0]   issue_src2;
  logic            issue_ok;

  // ALU write-back request
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  // LSU write-back request
  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  // Register-file write port and scoreboard
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [NREG-1:0] pending;

  modport slave (
    input  issue_valid, issue_rd, issue_src1, issue_src2,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output issue_ok, alu_ready, lsu_ready,
    output rf_we, rf_waddr, rf_wdata, pending
  );

  modport master (
    output issue_valid, issue_rd, issue_src1, issue_src2,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  issue_ok, alu_ready, lsu_ready,
    input  rf_we, rf_waddr, rf_wdata, pending
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler and scoreboard for the 32x32 register file.
// Round-robin shares the single write port between ALU and LSU, registers the
// winning write for one cycle, and tracks outstanding writes for RAW/WAW stalls.
module regfile_wb_scheduler #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input logic                   clk,
  input logic                   rst,
  regfile_wb_scheduler_if.slave bus
);

  typedef enum logic {GrantAlu, GrantLsu} grant_e;

  grant_e          last_grant_q, last_grant_d;
  logic            rf_we_q,      rf_we_d;
  logic [AW-1:0]   rf_waddr_q,   rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q,   rf_wdata_d;
  logic [NREG-1:0] pending_q,    pending_d;

  logic            alu_ready;
  logic            lsu_ready;
  logic            src1_busy;
  logic            src2_busy;
  logic            rd_busy;
  logic            issue_ok;
  logic            issue_set;

  // Round-robin grant; depends only on the valids and last_grant, and is held
  // off during reset so no handshake completes while state is being cleared.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (!rst) begin
      if (bus.alu_valid && bus.lsu_valid) begin
        alu_ready = (last_grant_q == GrantLsu);
        lsu_ready = (last_grant_q == GrantAlu);
      end else begin
        alu_ready = bus.alu_valid;
        lsu_ready = bus.lsu_valid;
      end
    end
  end

  // Hazard check; x0 never reads as pending.
  always_comb begin
    src1_busy = (bus.issue_src1 != '0) && pending_q[bus.issue_src1];
    src2_busy = (bus.issue_src2 != '0) && pending_q[bus.issue_src2];
    rd_busy   = (bus.issue_rd   != '0) && pending_q[bus.issue_rd];
    issue_ok  = !(src1_busy || src2_busy || rd_busy);
    issue_set = bus.issue_valid && issue_ok && (bus.issue_rd != '0);
  end

  // Latch the granted write; rd=0 completes the handshake but never writes.
  always_comb begin
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    if (alu_ready) begin
      last_grant_d = GrantAlu;
      rf_we_d      = (bus.alu_rd != '0);
      rf_waddr_d   = bus.alu_rd;
      rf_wdata_d   = bus.alu_data;
    end else if (lsu_ready) begin
      last_grant_d = GrantLsu;
      rf_we_d      = (bus.lsu_rd != '0);
      rf_waddr_d   = bus.lsu_rd;
      rf_wdata_d   = bus.lsu_data;
    end
  end

  // Scoreboard update; the set is applied after the clear so a newer producer wins.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) begin
      pending_d[rf_waddr_q] = 1'b0;
    end
    if (issue_set) begin
      pending_d[bus.issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers; asynchronous reset drops any latched write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GrantLsu;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      pending_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      pending_q    <= pending_d;
    end
  end

  assign bus.alu_ready = alu_ready;
  assign bus.lsu_ready = lsu_ready;
  assign bus.issue_ok  = issue_ok;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.pending   = pending_q;

  // Protocol invariants of the arbiter and scoreboard.
  a_alu_ready_needs_valid : assert property (@(posedge clk) disable iff (rst)
    bus.alu_ready |-> bus.alu_valid);
  a_lsu_ready_needs_valid : assert property (@(posedge clk) disable iff (rst)
    bus.lsu_ready |-> bus.lsu_valid);
  a_one_grant : assert property (@(posedge clk) disable iff (rst)
    !(bus.alu_ready && bus.lsu_ready));
  a_x0_never_pending : assert property (@(posedge clk) disable iff (rst)
    !bus.pending[0]);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: a behavioural model of grants, the one-cycle
// write stage and the scoreboard is compared against the DUT on every falling
// edge, and directed scenarios add literal expectations.
module tb_regfile_wb_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_scheduler_if bus ();

  regfile_wb_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: who was granted last, the write in flight, outstanding registers.
  logic        m_last_alu = 1'b0;
  logic        m_we       = 1'b0;
  logic [4:0]  m_waddr    = '0;
  logic [31:0] m_wdata    = '0;
  logic [31:0] m_pend     = '0;

  function automatic logic busy(input logic [4:0] r);
    return (r != 5'd0) && m_pend[r];
  endfunction

  function automatic logic e_alu_ready();
    return bus.alu_valid && (!bus.lsu_valid || !m_last_alu);
  endfunction

  function automatic logic e_lsu_ready();
    return bus.lsu_valid && (!bus.alu_valid || m_last_alu);
  endfunction

  function automatic logic e_issue_ok();
    return !(busy(bus.issue_src1) || busy(bus.issue_src2) || busy(bus.issue_rd));
  endfunction

  function automatic logic [31:0] next_pend();
    logic [31:0] v;
    v = m_pend;
    if (m_we) v[m_waddr] = 1'b0;
    if (bus.issue_valid && e_issue_ok() && bus.issue_rd != 5'd0) v[bus.issue_rd] = 1'b1;
    v[0] = 1'b0;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last_alu <= 1'b0;
      m_we       <= 1'b0;
      m_waddr    <= '0;
      m_wdata    <= '0;
      m_pend     <= '0;
    end else begin
      m_pend <= next_pend();
      if (e_alu_ready()) begin
        m_last_alu <= 1'b1;
        m_we       <= (bus.alu_rd != 5'd0);
        m_waddr    <= bus.alu_rd;
        m_wdata    <= bus.alu_data;
      end else if (e_lsu_ready()) begin
        m_last_alu <= 1'b0;
        m_we       <= (bus.lsu_rd != 5'd0);
        m_waddr    <= bus.lsu_rd;
        m_wdata    <= bus.lsu_data;
      end else begin
        m_we <= 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("alu_ready", bus.alu_ready, e_alu_ready());
      check("lsu_ready", bus.lsu_ready, e_lsu_ready());
      check("rf_we",     bus.rf_we,     m_we);
      check("rf_waddr",  bus.rf_waddr,  m_waddr);
      check("rf_wdata",  bus.rf_wdata,  m_wdata);
      check("pending",   bus.pending,   m_pend);
      if (bus.issue_valid) check("issue_ok", bus.issue_ok, e_issue_ok());
    end
  end

  task automatic set_issue(input logic v, input logic [4:0] rd, input logic [4:0] s1,
                           input logic [4:0] s2);
    bus.issue_valid = v;
    bus.issue_rd    = rd;
    bus.issue_src1  = s1;
    bus.issue_src2  = s2;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.lsu_valid = v;
    bus.lsu_rd    = rd;
    bus.lsu_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_we", bus.rf_we, 1'b0);
    check("reset_pending", bus.pending, 32'h0);
    rst = 1'b0;

    // Get a write in flight and a pending bit, then reset mid-cycle.
    set_issue(1'b1, 5'd10, 5'd0, 5'd0);
    set_alu(1'b1, 5'd1, 32'hA1);
    set_lsu(1'b1, 5'd2, 32'hB2);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    set_alu(1'b0, 5'd0, 32'h0);
    check("pre_rst_rf_we", bus.rf_we, 1'b1);
    check("pre_rst_pending", bus.pending, 32'h0000_0400);
    #2 rst = 1'b1;
    #1;
    check("rst_rf_we", bus.rf_we, 1'b0);
    check("rst_rf_waddr", bus.rf_waddr, 5'd0);
    check("rst_rf_wdata", bus.rf_wdata, 32'h0);
    check("rst_pending", bus.pending, 32'h0);
    check("rst_lsu_ready", bus.lsu_ready, 1'b0);

    // Release with both requesters valid: ALU must win first, then alternate.
    tick();
    set_alu(1'b1, 5'd3, 32'h1111_1111);
    set_lsu(1'b1, 5'd4, 32'h2222_2222);
    rst = 1'b0;
    #1;
    check("first_alu_ready", bus.alu_ready, 1'b1);
    check("first_lsu_ready", bus.lsu_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("conf_rf_we", bus.rf_we, 1'b1);
      check("conf_rf_waddr", bus.rf_waddr, (i % 2 == 0) ? 5'd3 : 5'd4);
      check("conf_rf_wdata", bus.rf_wdata,
            (i % 2 == 0) ? 32'h1111_1111 + 32'(i / 2) : 32'h2222_2222 + 32'(i / 2));
      if (i % 2 == 0) bus.alu_data = 32'h1111_1111 + 32'(i / 2 + 1);
      else            bus.lsu_data = 32'h2222_2222 + 32'(i / 2 + 1);
      if (i == 3) begin
        set_alu(1'b0, 5'd0, 32'h0);
        set_lsu(1'b0, 5'd0, 32'h0);
      end
    end
    tick();
    check("conf_done_rf_we", bus.rf_we, 1'b0);

    // RAW stall on x5 released one edge after the write-back handshake.
    set_issue(1'b1, 5'd5, 5'd0, 5'd0);
    tick();
    check("raw_pending5", bus.pending[5], 1'b1);
    set_issue(1'b1, 5'd0, 5'd5, 5'd0);
    #1;
    check("raw_stall", bus.issue_ok, 1'b0);
    set_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    set_alu(1'b0, 5'd0, 32'h0);
    #1;
    check("raw_stall_n1", bus.issue_ok, 1'b0);
    check("raw_rf_waddr", bus.rf_waddr, 5'd5);
    check("raw_rf_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    tick();
    check("raw_release", bus.issue_ok, 1'b1);
    check("raw_pending5_clr", bus.pending[5], 1'b0);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);

    // Set and clear of x7 on the same edge: set wins.
    set_alu(1'b1, 5'd7, 32'h77);
    tick();
    set_alu(1'b0, 5'd0, 32'h0);
    set_issue(1'b1, 5'd7, 5'd0, 5'd0);
    #1;
    check("waw_issue_ok", bus.issue_ok, 1'b1);
    check("waw_rf_waddr", bus.rf_waddr, 5'd7);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    check("waw_pending7", bus.pending[7], 1'b1);

    // x0 write-back and x0 issue.
    set_lsu(1'b1, 5'd0, 32'h55);
    #1;
    check("x0_lsu_ready", bus.lsu_ready, 1'b1);
    tick();
    set_lsu(1'b0, 5'd0, 32'h0);
    check("x0_rf_we", bus.rf_we, 1'b0);
    set_issue(1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    check("x0_issue_ok", bus.issue_ok, 1'b1);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0);
    check("x0_pending", bus.pending, 32'h0000_0080);

    // Write-back to a register with no outstanding write.
    set_alu(1'b1, 5'd9, 32'h99);
    tick();
    set_alu(1'b0, 5'd0, 32'h0);
    check("stray_rf_we", bus.rf_we, 1'b1);
    check("stray_rf_waddr", bus.rf_waddr, 5'd9);
    tick();
    check("stray_pending", bus.pending, 32'h0000_0080);
    check("stray_rf_we_off", bus.rf_we, 1'b0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
